// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Drives the open-drain ps2_clk/ps2_data pads via low-active output enables only.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       rx_block,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQUEST, S_SHIFT, S_WAIT_ACK, S_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    shreg_q, shreg_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] inh_cnt_q, inh_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  // Pad synchronizers reset to 1 (idle bus level) so reset never fakes a falling edge.
  logic clk_s1_q, clk_s2_q, clk_prev_q, data_s1_q, data_s2_q;
  logic fall, timeout;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_in;
      data_s2_q  <= data_s1_q;
    end
  end

  assign fall    = clk_prev_q & ~clk_s2_q;
  assign timeout = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
        if (tx_start) begin
          shreg_d   = {1'b1, ~^tx_data, tx_data};
          bit_cnt_d = 4'd0;
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          busy_d    = 1'b1;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        inh_cnt_d = inh_cnt_q + IW'(1);
        if (inh_cnt_q == IW'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          state_d   = S_REQUEST;
        end
      end
      S_REQUEST: begin
        clk_oe_d = 1'b0;
        to_cnt_d = '0;
        state_d  = S_SHIFT;
      end
      default: begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          busy_d    = 1'b0;
          error_d   = 1'b1;
          state_d   = S_IDLE;
        end else if (state_q == S_SHIFT) begin
          // The stop bit is a 1 in the register, so the 10th fall releases data.
          if (fall) begin
            data_oe_d = ~shreg_q[0];
            shreg_d   = {1'b1, shreg_q[9:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) state_d = S_WAIT_ACK;
          end
        end else if (state_q == S_WAIT_ACK) begin
          if (fall) begin
            if (!data_s2_q) begin
              state_d = S_WAIT_IDLE;
            end else begin
              busy_d  = 1'b0;
              error_d = 1'b1;
              state_d = S_IDLE;
            end
          end
        end else begin
          if (clk_s2_q && data_s2_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign tx_busy     = busy_q;
  assign rx_block    = busy_q;
  assign tx_done     = done_q;
  assign tx_error    = error_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error, rx_block;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_lo = 1'b0;
  logic       dev_data_lo = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0, frame_cnt = 0;
  logic clk_oe_prev = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_lo);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_lo);

  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(4000)) dut (
    .clock(clock), .reset(reset), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error), .rx_block(rx_block),
    .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
    if (ps2_clk_oe && !clk_oe_prev) frame_cnt++;
    clk_oe_prev = ps2_clk_oe;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge clock);
    tx_start = 1'b0;
  endtask

  task automatic dev_pulse(output logic sample);
    dev_clk_lo = 1'b1;
    repeat (20) @(negedge clock);
    dev_clk_lo = 1'b0;
    sample = ps2_data_in;
    repeat (20) @(negedge clock);
  endtask

  task automatic wait_request(output logic ok);
    int n = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 200) begin
      @(negedge clock);
      n++;
    end
    ok = (ps2_data_oe && !ps2_clk_oe);
    check("request_seen", 32'(ok), 32'd1);
  endtask

  // Device side of one frame: clocks 10 bits in on rising edges, then the ACK pulse.
  task automatic dev_receive(input logic do_ack, output logic [9:0] bits);
    logic ok, s;
    bits = '0;
    wait_request(ok);
    if (!ok) return;
    repeat (10) @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      dev_pulse(s);
      bits[i] = s;
    end
    if (do_ack) dev_data_lo = 1'b1;
    repeat (5) @(negedge clock);
    dev_pulse(s);
    dev_data_lo = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_outs"}, {26'd0, tx_busy, rx_block, tx_done, tx_error, ps2_clk_oe, ps2_data_oe}, 32'd0);
  endtask

  logic [9:0] bits;
  int d0, e0, f0, n;
  logic s;

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_idle("reset");

    // 0xED with ACK, including inhibit timing
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED);
    check("busy_after_accept", 32'(tx_busy), 32'd1);
    check("rx_block_after_accept", 32'(rx_block), 32'd1);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("inhibit_cycles", 32'(n), 32'd20);
    check("start_with_clk_low", 32'({ps2_clk_oe, ps2_data_oe}), 32'b11);
    @(negedge clock);
    check("clk_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'b01);
    dev_receive(1'b1, bits);
    check("ed_data", 32'(bits[7:0]), 32'hED);
    check("ed_parity", 32'(bits[8]), 32'd1);
    check("ed_stop", 32'(bits[9]), 32'd1);
    repeat (50) @(negedge clock);
    check("ed_done", 32'(done_cnt - d0), 32'd1);
    check("ed_no_error", 32'(err_cnt - e0), 32'd0);
    check_idle("ed_end");

    // 0xF4 parity
    d0 = done_cnt;
    send(8'hF4);
    dev_receive(1'b1, bits);
    check("f4_data", 32'(bits[7:0]), 32'hF4);
    check("f4_parity", 32'(bits[8]), 32'd0);
    repeat (50) @(negedge clock);
    check("f4_done", 32'(done_cnt - d0), 32'd1);

    // No ACK from device
    d0 = done_cnt; e0 = err_cnt;
    send(8'hF4);
    dev_receive(1'b0, bits);
    repeat (50) @(negedge clock);
    check("noack_error", 32'(err_cnt - e0), 32'd1);
    check("noack_no_done", 32'(done_cnt - d0), 32'd0);
    check_idle("noack_end");

    // Device never clocks: timeout counted from clk_oe release
    d0 = done_cnt; e0 = err_cnt;
    send(8'h12);
    wait_request(s);
    n = 0;
    while (!tx_error && n < 5000) begin
      @(negedge clock);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'd4000);
    check("timeout_data_oe", 32'(ps2_data_oe), 32'd0);
    check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
    repeat (5) @(negedge clock);
    check("timeout_error_once", 32'(err_cnt - e0), 32'd1);
    check("timeout_no_done", 32'(done_cnt - d0), 32'd0);

    // tx_start while busy must be ignored
    d0 = done_cnt; f0 = frame_cnt;
    send(8'hED);
    fork
      dev_receive(1'b1, bits);
      begin
        repeat (100) @(negedge clock);
        send(8'h55);
      end
    join
    repeat (300) @(negedge clock);
    check("busy_data", 32'(bits[7:0]), 32'hED);
    check("busy_one_done", 32'(done_cnt - d0), 32'd1);
    check("busy_one_frame", 32'(frame_cnt - f0), 32'd1);

    // Reset after the 5th fall
    send(8'h3C);
    wait_request(s);
    repeat (10) @(negedge clock);
    for (int i = 0; i < 4; i++) dev_pulse(s);
    dev_clk_lo = 1'b1;
    repeat (5) @(negedge clock);
    check("mid_busy", 32'(tx_busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check_idle("mid_reset");
    dev_clk_lo = 1'b0;
    reset = 1'b0;
    repeat (5) @(negedge clock);
    d0 = done_cnt;
    send(8'hFF);
    dev_receive(1'b1, bits);
    check("ff_data", 32'(bits[7:0]), 32'hFF);
    check("ff_parity", 32'(bits[8]), 32'd1);
    repeat (50) @(negedge clock);
    check("ff_done", 32'(done_cnt - d0), 32'd1);
    check("done_error_exclusive", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the FPGA to the keyboard over the shared open-drain ps2_clk/ps2_data lines, using the device-generated clock. It sits beside the existing PS/2 receive controller in the top-level wrapper. It drives the lines only through low-active output enables, and asserts `rx_block` so the receiver ignores its own traffic.

## Interface
- INHIBIT_CYCLES, 10000: system clocks ps2_clk is held low before the request (100 µs at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum system clocks from clock release to ACK (20 ms at 100 MHz).
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- tx_data  in  8  command byte; sampled on the accepted tx_start cycle.
- tx_start  in  1  single-cycle request; honoured only in IDLE.
- tx_busy  out  1  high from acceptance until return to IDLE.
- tx_done  out  1  one-cycle pulse; byte acknowledged by the device.
- tx_error  out  1  one-cycle pulse; no ACK or timeout.
- rx_block  out  1  equals tx_busy; gates the receiver.
- ps2_clk_in  in  1  raw pad value of ps2_clk (asynchronous).
- ps2_data_in  in  1  raw pad value of ps2_data (asynchronous).
- ps2_clk_oe  out  1  1 = drive ps2_clk low, 0 = release (pull-up).
- ps2_data_oe  out  1  1 = drive ps2_data low, 0 = release.

## Operation
- **Input sync:** ps2_clk_in and ps2_data_in each pass through a 2-FF synchronizer. A falling edge (`fall`) is previous synced clk = 1 and current = 0.
- **Frame:** start bit 0, then data bits 0–7 LSB first, then odd parity = ~^tx_data, then stop bit 1 (line released). The device then ACKs by driving data low.
- **Shift register:** a 10-bit register {stop=1, parity, tx_data} is loaded on accept. Bit count is 0–10.
- **IDLE:** all outputs 0. When tx_start is high, the block latches tx_data and goes to INHIBIT.
- **INHIBIT:** clk_oe = 1. A counter runs INHIBIT_CYCLES cycles. On the last cycle data_oe is set to 1 (start bit), then the block goes to REQUEST.
- **REQUEST:** clk_oe = 0 and data_oe = 1. The timeout counter is cleared, then the block goes to SHIFT.
- **SHIFT:** on each `fall`, data_oe = ~shreg[0], the register shifts right, and the count increments.
  - Falls 1–8 present data bits 0–7.
  - Fall 9 presents parity.
  - Fall 10 releases data (stop).
  - After fall 10, the block goes to WAIT_ACK.
- **WAIT_ACK:** on the next `fall`, the synced data is sampled.
  - If data = 0, go to WAIT_IDLE.
  - If data = 1, pulse tx_error and go to IDLE.
- **WAIT_IDLE:** wait for synced clk = 1 and data = 1. Then pulse tx_done and go to IDLE.
- **Timeout:** the counter runs in REQUEST, SHIFT, WAIT_ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES, both oe outputs go to 0, tx_error pulses and the block returns to IDLE.
- **Mutual exclusion:** tx_done and tx_error never assert together. At most one of them pulses per accepted command.
- **tx_start while busy** is ignored; it is not queued.
- **Open-drain rule:** oe outputs never drive high. clk_oe and data_oe are never both 0 → 1 in the same cycle except on the INHIBIT→data_oe step.

## Timing
- **Reset:** all outputs are 0 the cycle after reset is sampled high, including mid-frame. Both lines are released, counters cleared, state = IDLE.
- **Accept:** with tx_start high at edge N, tx_busy = 1 and clk_oe = 1 from N+1.
- **Start bit:** data_oe rises INHIBIT_CYCLES cycles after clk_oe rises. clk_oe falls one cycle later.
- **Bit latency:** data_oe updates 3 system clocks after the physical ps2_clk falling edge (2 sync + 1 register). This is well within the ≥30 µs low half-period.
- **Completion:** tx_done or tx_error is high for exactly one cycle. tx_busy falls on the same edge that raises the pulse.
- **Back-to-back:** a new tx_start is accepted on the cycle after tx_busy falls.
- **Registers:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
Bench parameters: INHIBIT_CYCLES = 20, TIMEOUT_CYCLES = 4000. The bench uses a behavioural device model with a 40-cycle clock period and pull-up resolution.

- **0xED with ACK:**
  - Stimulus: send 0xED; the model ACKs.
  - Required: clk held low for 20 cycles, then start 0; model captures bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Required on completion: tx_done pulses once, tx_busy = 0, both oe = 0.
- **0xF4 parity:**
  - Stimulus: send 0xF4.
  - Required: captured byte 0xF4, parity bit 0, tx_done.
- **No ACK:**
  - Stimulus: the model leaves data high on the 11th fall.
  - Required: tx_error pulses once, no tx_done, state IDLE.
- **Timeout:**
  - Stimulus: the model never clocks after the request.
  - Required: tx_error exactly 4000 cycles after clk_oe falls; ps2_data_oe = 0 after.
- **Busy ignore:**
  - Stimulus: tx_start with 0x55 during the 0xED frame.
  - Required: the frame still carries 0xED; only one tx_done; no second frame.
- **Reset mid-shift:**
  - Stimulus: assert reset after the 5th fall.
  - Required: the next cycle, all outputs are 0; a subsequent send of 0xFF completes with parity 1 and tx_done.
